// File: rtl/uart_packet_ctrl.sv
// Packet-level responder for the UART ALU: parses host command packets into
// opcode + 32-bit operand beats, and serializes 32-bit results as 4 bytes MSB first.
module uart_packet_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  op_opcode_o,
    output logic [31:0] op_data_o,
    output logic        op_last_o,
    output logic        op_valid_o,
    input  logic        op_ready_i,
    input  logic [31:0] res_data_i,
    input  logic        res_valid_i,
    output logic        res_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        err_o
);
    typedef enum logic [2:0] {P_OPCODE, P_RSVD, P_LEN_LO, P_LEN_HI, P_DATA} pstate_t;
    typedef enum logic {S_IDLE, S_SEND} sstate_t;

    pstate_t     r_pstate;
    sstate_t     r_sstate;
    logic [7:0]  r_len_lo;
    logic [15:0] r_rem;
    logic [13:0] r_words_rem;
    logic [1:0]  r_tail;
    logic [1:0]  r_bcnt;
    logic [23:0] r_acc;
    logic [7:0]  r_opcode;
    logic [31:0] r_data;
    logic        r_last;
    logic        r_valid;
    logic        r_rx_ready;
    logic        r_err;
    logic [31:0] r_shift;
    logic [1:0]  r_cnt;
    logic        r_tx_valid;
    logic        r_res_ready;

    logic        w_rx_hs;
    logic        w_op_hs;
    logic [15:0] w_len;
    logic [15:0] w_body;

    assign w_rx_hs = rx_valid_i & r_rx_ready;
    assign w_op_hs = r_valid & op_ready_i;
    assign w_len   = {rx_data_i, r_len_lo};
    assign w_body  = w_len - 16'd4;

    // Packet parser; rx_ready is the registered complement of op_valid
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pstate    <= P_OPCODE;
            r_len_lo    <= 8'd0;
            r_rem       <= 16'd0;
            r_words_rem <= 14'd0;
            r_tail      <= 2'd0;
            r_bcnt      <= 2'd0;
            r_acc       <= 24'd0;
            r_opcode    <= 8'd0;
            r_data      <= 32'd0;
            r_last      <= 1'b0;
            r_valid     <= 1'b0;
            r_rx_ready  <= 1'b1;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_op_hs) begin
                r_valid    <= 1'b0;
                r_rx_ready <= 1'b1;
            end
            if (w_rx_hs) begin
                case (r_pstate)
                    P_OPCODE: begin
                        r_opcode <= rx_data_i;
                        r_pstate <= P_RSVD;
                    end
                    P_RSVD:   r_pstate <= P_LEN_LO;
                    P_LEN_LO: begin
                        r_len_lo <= rx_data_i;
                        r_pstate <= P_LEN_HI;
                    end
                    P_LEN_HI: begin
                        if (w_len <= 16'd4) begin
                            r_err    <= 1'b1;
                            r_pstate <= P_OPCODE;
                        end else begin
                            r_rem       <= w_body;
                            r_words_rem <= w_body[15:2];
                            r_tail      <= w_body[1:0];
                            r_bcnt      <= 2'd0;
                            r_pstate    <= P_DATA;
                        end
                    end
                    P_DATA: begin
                        r_acc <= {r_acc[15:0], rx_data_i};
                        r_rem <= r_rem - 16'd1;
                        // Full words first; trailing partial bytes are discarded
                        if (r_words_rem != 14'd0) begin
                            r_bcnt <= r_bcnt + 2'd1;
                            if (r_bcnt == 2'd3) begin
                                r_data      <= {r_acc, rx_data_i};
                                r_valid     <= 1'b1;
                                r_rx_ready  <= 1'b0;
                                r_last      <= (r_words_rem == 14'd1) && (r_tail == 2'd0);
                                r_words_rem <= r_words_rem - 14'd1;
                            end
                        end
                        if (r_rem == 16'd1) begin
                            r_pstate <= P_OPCODE;
                            if (r_tail != 2'd0) r_err <= 1'b1;
                        end
                    end
                    default:  r_pstate <= P_OPCODE;
                endcase
            end
        end
    end

    // Result serializer, MSB byte first
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sstate    <= S_IDLE;
            r_shift     <= 32'd0;
            r_cnt       <= 2'd0;
            r_tx_valid  <= 1'b0;
            r_res_ready <= 1'b1;
        end else begin
            case (r_sstate)
                S_IDLE: begin
                    if (res_valid_i && r_res_ready) begin
                        r_shift     <= res_data_i;
                        r_cnt       <= 2'd0;
                        r_tx_valid  <= 1'b1;
                        r_res_ready <= 1'b0;
                        r_sstate    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (r_tx_valid && tx_ready_i) begin
                        r_shift <= {r_shift[23:0], 8'h00};
                        r_cnt   <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_tx_valid  <= 1'b0;
                            r_res_ready <= 1'b1;
                            r_sstate    <= S_IDLE;
                        end
                    end
                end
                default: r_sstate <= S_IDLE;
            endcase
        end
    end

    assign rx_ready_o  = r_rx_ready;
    assign op_opcode_o = r_opcode;
    assign op_data_o   = r_data;
    assign op_last_o   = r_last;
    assign op_valid_o  = r_valid;
    assign res_ready_o = r_res_ready;
    assign tx_data_o   = r_shift[31:24];
    assign tx_valid_o  = r_tx_valid;
    assign err_o       = r_err;
endmodule

// File: tb/tb_uart_packet_ctrl.sv
// Scoreboard bench for uart_packet_ctrl: drivers push expected beats/bytes/error
// cycles, a negedge monitor pops and compares them as the DUT presents them.
module tb_uart_packet_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  op_opcode_o;
    logic [31:0] op_data_o;
    logic        op_last_o;
    logic        op_valid_o;
    logic        op_ready_i;
    logic [31:0] res_data_i;
    logic        res_valid_i;
    logic        res_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        err_o;

    uart_packet_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .op_opcode_o(op_opcode_o), .op_data_o(op_data_o), .op_last_o(op_last_o),
        .op_valid_o(op_valid_o), .op_ready_i(op_ready_i),
        .res_data_i(res_data_i), .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] d;
        logic        last;
        int          rise;
    } beat_t;

    beat_t      exp_op[$];
    logic [7:0] exp_tx[$];
    int         exp_err[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic       mon_en = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got unexpected event expected none (cycle %0d)", name, cyc);
    endtask

    // Monitor: compares everything the DUT presents against the scoreboard
    logic       prev_opv = 1'b0;
    logic       prev_txv = 1'b0;
    logic       prev_txr = 1'b0;
    logic [7:0] prev_txd = 8'h00;
    always @(negedge clk_i) begin
        if (mon_en && !rst_i) begin
            if (op_valid_o && !prev_opv) begin
                if (exp_op.size() == 0) fail("op_unexpected");
                else check("op_rise_cycle", 32'(cyc), 32'(exp_op[0].rise));
            end
            if (op_valid_o && op_ready_i) begin
                if (exp_op.size() == 0) fail("op_hs_unexpected");
                else begin
                    check("op_opcode", 32'(op_opcode_o), 32'(exp_op[0].op));
                    check("op_data", op_data_o, exp_op[0].d);
                    check("op_last", 32'(op_last_o), 32'(exp_op[0].last));
                    void'(exp_op.pop_front());
                end
            end
            if (err_o) begin
                if (exp_err.size() == 0) fail("err_unexpected");
                else check("err_cycle", 32'(cyc), 32'(exp_err.pop_front()));
            end
            if (prev_txv && !prev_txr)
                check("tx_hold", 32'({tx_valid_o, tx_data_o}), 32'({1'b1, prev_txd}));
            if (tx_valid_o && tx_ready_i) begin
                if (exp_tx.size() == 0) fail("tx_unexpected");
                else check("tx_byte", 32'(tx_data_o), 32'(exp_tx.pop_front()));
            end
        end
        prev_opv = op_valid_o;
        prev_txv = tx_valid_o;
        prev_txr = tx_ready_i;
        prev_txd = tx_data_o;
    end

    // Random tx back-pressure
    initial begin
        tx_ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1 tx_ready_i = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, output int k);
        int n;
        n = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(negedge clk_i);
        while (!rx_ready_o && n < 1000) begin
            n++;
            @(negedge clk_i);
        end
        if (!rx_ready_o) fail("rx_accept_timeout");
        k = cyc;
        @(posedge clk_i);
        #1 rx_valid_i = 1'b0;
    endtask

    function automatic beat_t mk(input logic [7:0] op, input logic [31:0] d,
                                 input logic last, input int rise);
        beat_t b;
        b.op = op; b.d = d; b.last = last; b.rise = rise;
        return b;
    endfunction

    logic [7:0] pkt[$];
    int         k;
    logic       ok;
    int         n;

    initial begin
        rst_i = 1'b1; rx_data_i = 8'h00; rx_valid_i = 1'b0; op_ready_i = 1'b1;
        res_data_i = 32'h0; res_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        mon_en = 1'b1;

        // Reset state held for 20 cycles
        ok = 1'b1;
        @(negedge clk_i);
        check("rst_rx_ready", 32'(rx_ready_o), 32'd1);
        check("rst_res_ready", 32'(res_ready_o), 32'd1);
        check("rst_tx_data", 32'(tx_data_o), 32'd0);
        check("rst_op_regs", {op_opcode_o, 23'd0, op_last_o}, 32'd0);
        check("rst_op_data", op_data_o, 32'd0);
        repeat (20) begin
            ok &= rx_ready_o && res_ready_o && !op_valid_o && !tx_valid_o && !err_o;
            @(negedge clk_i);
        end
        check("rst_idle_20", 32'(ok), 32'd1);

        // Two-word packet
        @(posedge clk_i); #1;
        pkt = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78,
                8'hDE, 8'hAD, 8'hBE, 8'hEF};
        foreach (pkt[i]) begin
            send_byte(pkt[i], k);
            if (i == 7)  exp_op.push_back(mk(8'h10, 32'h12345678, 1'b0, k + 1));
            if (i == 11) exp_op.push_back(mk(8'h10, 32'hDEADBEEF, 1'b1, k + 1));
        end
        repeat (5) @(posedge clk_i);

        // Same packet with the ALU stalled after the first beat
        #1 op_ready_i = 1'b0;
        fork
            begin
                foreach (pkt[i]) begin
                    send_byte(pkt[i], k);
                    if (i == 7)  exp_op.push_back(mk(8'h10, 32'h12345678, 1'b0, k + 1));
                    if (i == 11) exp_op.push_back(mk(8'h10, 32'hDEADBEEF, 1'b1, k + 1));
                end
            end
            begin
                n = 0;
                @(negedge clk_i);
                while (!op_valid_o && n < 1000) begin n++; @(negedge clk_i); end
                check("stall_beat_seen", 32'(op_valid_o), 32'd1);
                ok = 1'b1;
                repeat (200) begin
                    ok &= op_valid_o && !rx_ready_o && (op_data_o == 32'h12345678)
                          && (op_opcode_o == 8'h10) && !op_last_o;
                    @(negedge clk_i);
                end
                check("stall_hold", 32'(ok), 32'd1);
                @(posedge clk_i);
                #1 op_ready_i = 1'b1;
            end
        join
        repeat (5) @(posedge clk_i);

        // Length 4: no beats, error one cycle after length MSB
        #1;
        pkt = '{8'h30, 8'h00, 8'h04, 8'h00};
        foreach (pkt[i]) begin
            send_byte(pkt[i], k);
            if (i == 3) exp_err.push_back(k + 1);
        end
        repeat (5) @(posedge clk_i);

        // Length 9: one beat (not last), tail byte discarded, error after it
        #1;
        pkt = '{8'h31, 8'h00, 8'h09, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        foreach (pkt[i]) begin
            send_byte(pkt[i], k);
            if (i == 7) exp_op.push_back(mk(8'h31, 32'hAABBCCDD, 1'b0, k + 1));
            if (i == 8) exp_err.push_back(k + 1);
        end
        repeat (5) @(posedge clk_i);

        // Result serialization with random tx_ready
        #1 res_data_i = 32'hCAFEF00D;
        res_valid_i = 1'b1;
        @(negedge clk_i);
        check("res_ready_idle", 32'(res_ready_o), 32'd1);
        @(posedge clk_i);
        #1 res_valid_i = 1'b0;
        exp_tx.push_back(8'hCA); exp_tx.push_back(8'hFE);
        exp_tx.push_back(8'hF0); exp_tx.push_back(8'h0D);
        @(negedge clk_i);
        check("tx_latency", 32'({tx_valid_o, tx_data_o}), 32'h1CA);
        ok = 1'b1; n = 0;
        for (int t = 0; t < 500 && n < 4; t++) begin
            ok &= !res_ready_o;
            if (tx_valid_o && tx_ready_i) n++;
            if (n < 4) @(negedge clk_i);
        end
        check("res_ready_low", 32'(ok), 32'd1);
        check("tx_count", 32'(n), 32'd4);
        @(negedge clk_i);
        check("res_ready_back", 32'(res_ready_o), 32'd1);
        check("tx_valid_off", 32'(tx_valid_o), 32'd0);

        // Reset mid-packet, then a clean single-word packet
        @(posedge clk_i); #1;
        pkt = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h12, 8'h34};
        foreach (pkt[i]) send_byte(pkt[i], k);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        pkt = '{8'h20, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05};
        foreach (pkt[i]) begin
            send_byte(pkt[i], k);
            if (i == 7) exp_op.push_back(mk(8'h20, 32'h00000005, 1'b1, k + 1));
        end
        repeat (20) @(posedge clk_i);

        @(negedge clk_i);
        check("op_queue_drained", 32'(exp_op.size()), 32'd0);
        check("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
        check("err_queue_drained", 32'(exp_err.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_packet_ctrl.md
# uart_packet_ctrl

Packet-level responder for the UART ALU, sitting between the `uart_rx` AXI-Stream byte output and the ALU datapath, and between the ALU result and the `uart_tx` byte input. It parses host command packets into an opcode plus a stream of 32-bit operands. It then serializes each 32-bit ALU result back to the host as four bytes, MSB first. Packet format, in byte order:

- opcode
- reserved byte
- length LSB
- length MSB
- operand words, each 4 bytes big-endian

## Interface
Parameters:
- none. Byte width is fixed at 8, operand and result width at 32, length field at 16.

Ports:
- `clk_i` in 1: single clock for the block.
- `rst_i` in 1: reset, synchronous, active-high.
- `rx_data_i` in 8: received byte, from `uart_rx` `m_axis_tdata`.
- `rx_valid_i` in 1: received byte valid.
- `rx_ready_o` out 1: block accepts the byte.
- `op_opcode_o` out 8: opcode of the current packet.
- `op_data_o` out 32: assembled operand word.
- `op_last_o` out 1: this is the final operand of the packet.
- `op_valid_o` out 1: operand beat valid.
- `op_ready_i` in 1: ALU accepts the beat.
- `res_data_i` in 32: ALU result.
- `res_valid_i` in 1: result valid.
- `res_ready_o` out 1: serializer is idle and takes the result.
- `tx_data_o` out 8: byte to `uart_tx` `s_axis_tdata`.
- `tx_valid_o` out 1: transmit byte valid.
- `tx_ready_i` in 1: `uart_tx` accepts the byte.
- `err_o` out 1: one-cycle pulse on a malformed packet.

## Operation
A handshake is a cycle with valid=1 and ready=1 on the same interface.

Parser FSM states: OPCODE, RSVD, LEN_LO, LEN_HI, DATA.
- OPCODE: latch `op_opcode_o` on byte handshake, go to RSVD.
- RSVD: consume the byte, content ignored, go to LEN_LO.
- LEN_LO / LEN_HI: build the 16-bit `len`; it counts total packet bytes including the 4-byte header.
- On the LEN_HI handshake:
  - Compute `words = (len-4)>>2` (14 bits) and `tail = (len-4)[1:0]`.
  - If `len <= 4`: pulse `err_o` next cycle, return to OPCODE, emit no beats.
  - Otherwise go to DATA.
- DATA:
  - Shift bytes into a 32-bit accumulator, MSB first, using a 2-bit byte counter.
  - On the 4th byte of a word: load `op_data_o`, set `op_valid_o`, and set `op_last_o = (words_remaining==1 && tail==0)`.
  - After the full words, consume `tail` bytes and discard them.
  - When the remaining byte count reaches 0:
    - Return to OPCODE.
    - If `tail != 0`, pulse `err_o` one cycle after the final byte handshake.
    - If `tail != 0 && words > 0`, the last full word carries `op_last_o=0`. This is accepted as an error case; the ALU relies on `err_o`.

`rx_ready_o`:
- Equals `~op_valid_o`, driven from a register.
- This gives a one-entry output buffer with one bubble; UART byte spacing (~1400 cycles) hides the bubble.
- `op_valid_o` clears on the cycle after its handshake.
- The `op_*` outputs hold stable while `op_valid_o=1 && op_ready_i=0`.

Serializer FSM states: IDLE, SEND.
- IDLE: `res_ready_o=1`. On result handshake, capture `res_data_i` into a shift register, `cnt=0`, go to SEND.
- SEND: `tx_valid_o=1`, `tx_data_o=shift[31:24]`. On tx handshake, shift left by 8 and increment `cnt`. On the handshake with `cnt==3`, go to IDLE.
- Parser and serializer run independently; simultaneous events on both sides are legal.

## Timing
- Reset values:
  - `rx_ready_o=1`, `res_ready_o=1`.
  - `op_valid_o=0`, `op_last_o=0`, `op_opcode_o=0`, `op_data_o=0`.
  - `tx_valid_o=0`, `tx_data_o=0`, `err_o=0`.
  - Both FSMs in their initial state (OPCODE, IDLE).
- Reset mid-packet or mid-response: all state is dropped, and the next byte is parsed as an opcode.
- Parse latency: `op_valid_o` rises 1 cycle after the 4th byte handshake of a word.
- Response latency: `tx_valid_o` with the MSB rises 1 cycle after the result handshake. `res_ready_o` returns to 1 one cycle after the 4th tx handshake.
- `tx_data_o` / `tx_valid_o` change only after a tx handshake; they never drop while waiting on `tx_ready_i`.

## Test plan
- Reset -> `rx_ready_o=1`, `res_ready_o=1`, all valids and `err_o` stay 0 for 20 cycles.
- Bytes 10 00 0C 00 12 34 56 78 DE AD BE EF -> two beats:
  - opcode 0x10, data 0x12345678, last=0;
  - opcode 0x10, data 0xDEADBEEF, last=1;
  - `err_o` never asserted.
- Same packet with `op_ready_i=0` for 200 cycles after the first beat -> `rx_ready_o=0`, first beat stable; after release, second beat correct.
- Malformed packets:
  - length 0x0004 -> no beats, `err_o` pulse 1 cycle after the length MSB handshake.
  - length 0x0009 with data AA BB CC DD EE -> beat 0xAABBCCDD last=0, then `err_o` pulse after the EE handshake, parser back in OPCODE.
- Result 0xCAFEF00D with `tx_ready_i` toggled randomly -> bytes CA, FE, F0, 0D in order; `res_ready_o=0` until the last handshake.
- `rst_i` pulsed after 2 data bytes of a packet, then valid packet 20 00 08 00 00 00 00 05 -> single beat, opcode 0x20, data 0x00000005, last=1.
